// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool for one channel, using a half-width line buffer.
// Build macro POOL_RELU_EN: when defined, negative pooled results are clamped to zero.
module maxpool_2x2_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pool_en,
    output logic              pool_done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    // state | meaning
    // IDLE  | waiting for a pool_en rising edge
    // RUN   | consuming the input frame in raster order
    // FLUSH | final pixel taken, waiting for the output register to drain
    // DONE  | frame complete; pool_done fires on the following cycle

    localparam int LB_N  = IMG_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int LAST_OUT_ROW = (IMG_H % 2 == 1) ? IMG_H - 2 : IMG_H - 1;
    localparam int LAST_OUT_COL = (IMG_W % 2 == 1) ? IMG_W - 2 : IMG_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                    r_state;
    logic                      r_pool_en_d;
    logic [COL_W-1:0]          r_col;
    logic [ROW_W-1:0]          r_row;
    logic signed [DATA_W-1:0]  r_pair;
    logic signed [DATA_W-1:0]  r_linebuf [LB_N];
    logic                      r_out_valid;
    logic signed [DATA_W-1:0]  r_out_data;
    logic                      r_out_last;
    logic                      r_pool_done;

    logic                      w_in_ready;
    logic                      w_in_xfer;
    logic signed [DATA_W-1:0]  w_in_px;
    logic                      w_col_last;
    logic                      w_row_last;
    logic                      w_last_px;
    logic                      w_is_last_out;
    logic [LB_AW-1:0]          w_lb_idx;
    logic signed [DATA_W-1:0]  w_h;
    logic signed [DATA_W-1:0]  w_v;
    logic signed [DATA_W-1:0]  w_pool;
    logic                      w_wr;
    logic                      w_start;
    logic                      w_abort;
    logic                      w_drain_ok;

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_drain_ok    = !r_out_valid || out_ready;
    assign w_in_ready    = (r_state == S_RUN) && w_drain_ok;
    assign w_in_xfer     = in_valid && w_in_ready;
    assign w_in_px       = $signed(in_data);
    assign w_col_last    = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last    = (r_row == ROW_W'(IMG_H - 1));
    assign w_last_px     = w_in_xfer && w_col_last && w_row_last;
    assign w_is_last_out = (r_row == ROW_W'(LAST_OUT_ROW)) && (r_col == COL_W'(LAST_OUT_COL));
    assign w_lb_idx      = LB_AW'(r_col >> 1);
    assign w_h           = smax(r_pair, w_in_px);
    assign w_v           = smax(r_linebuf[w_lb_idx], w_h);
    assign w_wr          = w_in_xfer && r_col[0] && r_row[0];
    assign w_start       = (r_state == S_IDLE) && pool_en && !r_pool_en_d;
    assign w_abort       = ((r_state == S_RUN) || (r_state == S_FLUSH)) && !pool_en;

`ifdef POOL_RELU_EN
    assign w_pool = w_v[DATA_W-1] ? '0 : w_v;
`else
    assign w_pool = w_v;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pool_en_d <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_pair      <= '0;
            for (int i = 0; i < LB_N; i++) begin
                r_linebuf[LB_AW'(i)] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_pool_done <= 1'b0;
        end else begin
            r_pool_en_d <= pool_en;
            r_pool_done <= 1'b0;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_col       <= '0;
                r_row       <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_last_px) r_state <= S_FLUSH;
                    end
                    S_FLUSH: begin
                        if (w_drain_ok) r_state <= S_DONE;
                    end
                    S_DONE: begin
                        r_pool_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase

                if (w_in_xfer) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                    // Even column opens a pair; odd column of an even row parks the row max.
                    if (!r_col[0]) begin
                        r_pair <= w_in_px;
                    end else if (!r_row[0]) begin
                        r_linebuf[w_lb_idx] <= w_h;
                    end
                end

                if (w_wr) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_pool;
                    r_out_last  <= w_is_last_out;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign pool_done = r_pool_done;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: three geometries (4x4, 5x3, 2x2) checked against a frame-level model.
`timescale 1ns/1ps
module tb_maxpool_2x2_stream;
    localparam int DW = 16;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] pool_en;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] out_ready;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] out_valid;
    logic [NI-1:0] out_last;
    logic [NI-1:0] pool_done;
    logic [DW-1:0] in_data  [NI];
    logic [DW-1:0] out_data [NI];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode [NI];

    int frame [NI][32];
    int exp_q [NI][$];
    int obs_q [NI][$];
    int obs_l [NI][$];
    int m_in [NI], m_out [NI];
    int last_in_cyc [NI], last_out_cyc [NI];
    int done_cyc [NI], done_seen_cyc [NI], done_cnt [NI];
    bit m_act [NI], m_fin [NI], prev_en [NI], prev_stall [NI], prev_last [NI];
    int prev_data [NI];

    int src_q [$];
    int want_q [$];

    always #5 clk = ~clk;

    maxpool_2x2_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_p44 (
        .clk(clk), .rst_n(rst_n), .pool_en(pool_en[0]), .pool_done(pool_done[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]));

    maxpool_2x2_stream #(.DATA_W(DW), .IMG_W(5), .IMG_H(3)) u_p53 (
        .clk(clk), .rst_n(rst_n), .pool_en(pool_en[1]), .pool_done(pool_done[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]));

    maxpool_2x2_stream #(.DATA_W(DW), .IMG_W(2), .IMG_H(2)) u_p22 (
        .clk(clk), .rst_n(rst_n), .pool_en(pool_en[2]), .pool_done(pool_done[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]));

    function automatic int img_w(input int k);
        case (k)
            0: return 4;
            1: return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int img_h(input int k);
        case (k)
            0: return 4;
            1: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            case (ready_mode[k])
                0:       out_ready[k] = 1'b1;
                1:       out_ready[k] = (cyc % 3 == 0);
                default: out_ready[k] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model: keep every accepted pixel of the frame and pool from the stored 2x2 window.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            int w, h, tin, tout, n, r, c, mx, sd, e;
            w = img_w(k);
            h = img_h(k);
            tin = w * h;
            tout = (w / 2) * (h / 2);
            sd = int'($signed(out_data[k]));
            if (!rst_n) begin
                m_act[k] = 1'b0; m_fin[k] = 1'b0;
                m_in[k] = 0; m_out[k] = 0; done_cyc[k] = -1;
                exp_q[k].delete();
                prev_en[k] = 1'b0; prev_stall[k] = 1'b0;
            end else begin
                if (pool_en[k] && !prev_en[k]) begin
                    m_act[k] = 1'b1; m_fin[k] = 1'b0;
                    m_in[k] = 0; m_out[k] = 0; done_cyc[k] = -1;
                    exp_q[k].delete();
                end
                if (!m_act[k]) check("in_ready_idle", int'(in_ready[k]), 0);
                if (in_valid[k] && in_ready[k]) begin
                    if (!m_act[k] || m_in[k] >= tin) begin
                        check("in_xfer_unexpected", int'(in_ready[k]), 0);
                    end else begin
                        n = m_in[k];
                        frame[k][n] = int'($signed(in_data[k]));
                        r = n / w;
                        c = n % w;
                        if ((r % 2 == 1) && (c % 2 == 1)) begin
                            mx = imax(imax(frame[k][(r-1)*w + c-1], frame[k][(r-1)*w + c]),
                                      imax(frame[k][r*w + c-1], frame[k][n]));
`ifdef POOL_RELU_EN
                            if (mx < 0) mx = 0;
`endif
                            exp_q[k].push_back(mx);
                        end
                        m_in[k]++;
                        if (m_in[k] == tin) begin
                            m_act[k] = 1'b0;
                            last_in_cyc[k] = cyc;
                        end
                    end
                end
                if (out_valid[k] && out_ready[k]) begin
                    obs_q[k].push_back(sd);
                    obs_l[k].push_back(int'(out_last[k]));
                    if (exp_q[k].size() == 0) begin
                        check("out_spurious", exp_q[k].size(), 1);
                    end else begin
                        e = exp_q[k].pop_front();
                        check("out_data", sd, e);
                        check("out_last", int'(out_last[k]), int'(m_out[k] == tout - 1));
                        m_out[k]++;
                        if (m_out[k] == tout) last_out_cyc[k] = cyc;
                    end
                end
                if (prev_stall[k] && prev_en[k]) begin
                    check("hold_valid", int'(out_valid[k]), 1);
                    check("hold_data", sd, prev_data[k]);
                    check("hold_last", int'(out_last[k]), int'(prev_last[k]));
                end
                if (out_valid[k] && !out_ready[k]) check("in_ready_stall", int'(in_ready[k]), 0);
                check("pool_done", int'(pool_done[k]), int'(done_cyc[k] == cyc));
                if (pool_done[k]) begin
                    done_cnt[k]++;
                    done_seen_cyc[k] = cyc;
                    check("done_outputs_left", exp_q[k].size(), 0);
                end
                if (!m_fin[k] && m_in[k] == tin && m_out[k] == tout) begin
                    done_cyc[k] = imax(last_out_cyc[k], last_in_cyc[k] + 1) + 2;
                    m_fin[k] = 1'b1;
                end
                if (prev_en[k] && !pool_en[k] && m_act[k]) begin
                    m_act[k] = 1'b0; m_in[k] = 0; m_out[k] = 0;
                    done_cyc[k] = -1;
                    exp_q[k].delete();
                end
                prev_stall[k] = out_valid[k] && !out_ready[k];
                prev_data[k]  = sd;
                prev_last[k]  = out_last[k];
                prev_en[k]    = pool_en[k];
            end
        end
    end

    task automatic start(input int k);
        @(posedge clk); #1 pool_en[k] = 1'b0;
        @(posedge clk); #1 pool_en[k] = 1'b1;
    endtask

    task automatic feed(input int k, input int cnt, input bit rnd_valid);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < cnt && guard < 3000) begin
            @(posedge clk); #1;
            in_valid[k] = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data[k]  = DW'(src_q[idx]);
            @(negedge clk);
            if (in_valid[k] && in_ready[k]) idx++;
            guard++;
        end
        check("feed_timeout", idx, cnt);
        @(posedge clk); #1 in_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int g;
        g = 0;
        while (!pool_done[k] && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("done_timeout", int'(pool_done[k]), 1);
        @(posedge clk); #1;
    endtask

    task automatic seq_src(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(i);
    endtask

    task automatic rand_src(input int n, input bit ties);
        src_q.delete();
        for (int i = 0; i < n; i++) begin
            if (ties) src_q.push_back(int'($urandom_range(0, 3)) - 2);
            else      src_q.push_back(int'($signed(16'($urandom))));
        end
    endtask

    task automatic check_obs(input string tag, input int k, input int base);
        check({tag, "_count"}, obs_q[k].size() - base, want_q.size());
        for (int i = 0; i < want_q.size() && base + i < obs_q[k].size(); i++) begin
            check({tag, "_data"}, obs_q[k][base + i], want_q[i]);
            check({tag, "_last"}, obs_l[k][base + i], int'(i == want_q.size() - 1));
        end
    endtask

    initial begin
        int base, dc;
        rst_n = 1'b0;
        pool_en = '0;
        in_valid = '0;
        for (int k = 0; k < NI; k++) begin
            in_data[k] = '0;
            ready_mode[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid[0]), 0);
        check("rst_in_ready", int'(in_ready[0]), 0);

        // 4x4 ramp, downstream always ready
        seq_src(16);
        want_q = '{5, 7, 13, 15};
        base = obs_q[0].size(); dc = done_cnt[0];
        start(0); feed(0, 16, 1'b0); wait_done(0);
        check_obs("t1", 0, base);
        check("t1_done_gap", done_seen_cyc[0] - last_out_cyc[0], 2);
        check("t1_done_cnt", done_cnt[0] - dc, 1);

        // same frame, downstream ready one cycle in three
        ready_mode[0] = 1;
        base = obs_q[0].size();
        start(0); feed(0, 16, 1'b0); wait_done(0);
        check_obs("t2", 0, base);

        // 5x3 ramp: trailing column and row are dropped
        seq_src(15);
        want_q = '{6, 8};
        base = obs_q[1].size();
        start(1); feed(1, 15, 1'b0); wait_done(1);
        check_obs("t3", 1, base);
        check("t3_done_gap", done_seen_cyc[1] - last_in_cyc[1], 3);

        // signed 2x2
        src_q = '{-3, -1, -7, -2};
`ifdef POOL_RELU_EN
        want_q = '{0};
`else
        want_q = '{-1};
`endif
        base = obs_q[2].size();
        start(2); feed(2, 4, 1'b0); wait_done(2);
        check_obs("t4", 2, base);

        // abort after six pixels, then a clean frame
        ready_mode[0] = 0;
        seq_src(16);
        dc = done_cnt[0];
        start(0); feed(0, 6, 1'b0);
        pool_en[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_out_valid", int'(out_valid[0]), 0);
        check("t5_in_ready", int'(in_ready[0]), 0);
        repeat (10) @(posedge clk);
        check("t5_no_done", done_cnt[0] - dc, 0);
        want_q = '{5, 7, 13, 15};
        base = obs_q[0].size();
        #1 start(0); feed(0, 16, 1'b0); wait_done(0);
        check_obs("t5", 0, base);

        // reset in the middle of a frame
        ready_mode[0] = 2;
        rand_src(16, 1'b0);
        start(0); feed(0, 5, 1'b1);
        rst_n = 1'b0;
        pool_en = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("t6_rst_out_valid", int'(out_valid[k]), 0);
            check("t6_rst_out_data", int'(out_data[k]), 0);
            check("t6_rst_out_last", int'(out_last[k]), 0);
            check("t6_rst_in_ready", int'(in_ready[k]), 0);
            check("t6_rst_pool_done", int'(pool_done[k]), 0);
        end

        // randomized frames on every geometry
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NI; k++) begin
                ready_mode[k] = it % 3;
                rand_src(img_w(k) * img_h(k), it[1]);
                start(k); feed(k, img_w(k) * img_h(k), it[0]); wait_done(k);
            end
        end

        // pool_en left high after a completed frame must not restart
        ready_mode[0] = 0;
        rand_src(16, 1'b0);
        start(0); feed(0, 16, 1'b1); wait_done(0);
        dc = done_cnt[0];
        in_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_hold_in_ready", int'(in_ready[0]), 0);
        end
        in_valid[0] = 1'b0;
        check("t6_hold_no_done", done_cnt[0] - dc, 0);
        check("t6_hold_out_valid", int'(out_valid[0]), 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
